// File: rtl/pulse_sorter.sv
// Pulse measurement for the comparator output: high width, rise-to-rise period and size class.
// Short pulses are rejected as glitches; overlong high times are reported once as class 3.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// WAIT_LOW | ignore sigin until a 0 is sampled (no partial pulses)
// LOW      | idle low, waiting for a rising sample
// HIGH     | counting high samples of the current pulse
module pulse_sorter #(
    parameter int CNT_W     = 16,
    parameter int MIN_WIDTH = 3,
    parameter int TH1       = 10,
    parameter int TH2       = 100,
    parameter int MAX_WIDTH = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cnt_clr,
    input  logic             sigin,
    output logic             pulse_valid,
    output logic [CNT_W-1:0] pulse_width,
    output logic [CNT_W-1:0] pulse_period,
    output logic [1:0]       pulse_class,
    output logic [31:0]      pulse_count,
    output logic [15:0]      glitch_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] TH1_W   = CNT_W'(TH1);
    localparam logic [CNT_W-1:0] TH2_W   = CNT_W'(TH2);
    localparam logic [CNT_W-1:0] MAX_W   = CNT_W'(MAX_WIDTH);

    typedef enum logic [1:0] {WAIT_LOW, LOW, HIGH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] since_q, since_d;   // edges since the last accepted rise
    logic [CNT_W-1:0] snap_q, snap_d;     // since_q captured at the current rise
    logic             ref_q, ref_d;       // a previous accepted rise exists
    logic             report;
    logic             glitch;
    logic [CNT_W-1:0] rep_width;
    logic [1:0]       rep_class;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == CNT_MAX) ? x : x + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOW;
            width_q <= '0;
            since_q <= '0;
            snap_q  <= '0;
            ref_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            since_q <= since_d;
            snap_q  <= snap_d;
            ref_q   <= ref_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        since_d   = sat_inc(since_q);
        snap_d    = snap_q;
        ref_d     = ref_q;
        report    = 1'b0;
        glitch    = 1'b0;
        rep_width = width_q;
        rep_class = 2'd0;
        if (!enable) begin
            state_d = WAIT_LOW;
            width_d = '0;
            since_d = '0;
            snap_d  = '0;
            ref_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOW: begin
                    if (!sigin) state_d = LOW;
                end
                LOW: begin
                    if (sigin) begin
                        state_d = HIGH;
                        width_d = {{(CNT_W-1){1'b0}}, 1'b1};
                        snap_d  = sat_inc(since_q);
                    end
                end
                HIGH: begin
                    if (sigin) begin
                        if (width_q == MAX_W - 1'b1) begin
                            report    = 1'b1;
                            rep_width = MAX_W;
                            rep_class = 2'd3;
                            state_d   = WAIT_LOW;
                            width_d   = '0;
                            since_d   = width_q;  // this edge is width_q edges after the rise
                            ref_d     = 1'b1;
                        end else begin
                            width_d = width_q + 1'b1;
                        end
                    end else begin
                        state_d = LOW;
                        width_d = '0;
                        if (width_q < MIN_W) begin
                            glitch = 1'b1;
                        end else begin
                            report  = 1'b1;
                            since_d = width_q;
                            ref_d   = 1'b1;
                            if (width_q < TH1_W)      rep_class = 2'd0;
                            else if (width_q < TH2_W) rep_class = 2'd1;
                            else                      rep_class = 2'd2;
                        end
                    end
                end
                default: state_d = WAIT_LOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_valid  <= 1'b0;
            pulse_width  <= '0;
            pulse_period <= '0;
            pulse_class  <= 2'd0;
            pulse_count  <= '0;
            glitch_count <= '0;
        end else begin
            pulse_valid <= report;
            if (report) begin
                pulse_width  <= rep_width;
                pulse_period <= ref_q ? snap_q : '0;
                pulse_class  <= rep_class;
            end
            if (cnt_clr)     pulse_count <= '0;
            else if (report) pulse_count <= pulse_count + 32'd1;
            if (cnt_clr)                               glitch_count <= '0;
            else if (glitch && glitch_count != 16'hFFFF) glitch_count <= glitch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pulse_sorter.sv
// Scoreboard bench for pulse_sorter: stimulus pushes expected reports, a monitor pops on each strobe.
module tb_pulse_sorter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        cnt_clr = 1'b0;
    logic        sigin = 1'b1;
    logic        pulse_valid;
    logic [15:0] pulse_width;
    logic [15:0] pulse_period;
    logic [1:0]  pulse_class;
    logic [31:0] pulse_count;
    logic [15:0] glitch_count;

    typedef struct {
        int w;
        int p;
        int c;
        int n;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    pulse_sorter #(
        .CNT_W(16), .MIN_WIDTH(3), .TH1(10), .TH2(100), .MAX_WIDTH(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cnt_clr(cnt_clr), .sigin(sigin),
        .pulse_valid(pulse_valid), .pulse_width(pulse_width), .pulse_period(pulse_period),
        .pulse_class(pulse_class), .pulse_count(pulse_count), .glitch_count(glitch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            sigin = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input int w, input int p, input int c, input int n);
        exp_t e;
        e.w = w; e.p = p; e.c = c; e.n = n;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && pulse_valid) begin
            exp_t e;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_strobe: got width=%0d class=%0d, expected no strobe",
                         pulse_width, pulse_class);
            end else begin
                e = exp_q.pop_front();
                if (int'(pulse_width) == e.w && int'(pulse_period) == e.p &&
                    int'(pulse_class) == e.c && int'(pulse_count) == e.n)
                    n_pass++;
                else
                    $display("FAIL strobe: got w=%0d p=%0d c=%0d n=%0d, expected w=%0d p=%0d c=%0d n=%0d",
                             pulse_width, pulse_period, pulse_class, pulse_count,
                             e.w, e.p, e.c, e.n);
            end
        end
    end

    initial begin
        // reset with sigin high
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", pulse_valid, 0);
        check("rst_count", pulse_count, 0);
        check("rst_glitch", glitch_count, 0);
        rst_n = 1'b1;

        // partial pulse after reset ignored, then 5-high, then 50-high
        drive(1, 20);
        drive(0, 5);
        expect_pulse(5, 0, 0, 1);
        drive(1, 5);
        drive(0, 15);
        expect_pulse(50, 20, 1, 2);
        drive(1, 50);
        drive(0, 10);

        // 5 / 15 low / 2 glitch / 8 low / 120
        expect_pulse(5, 60, 0, 3);
        drive(1, 5);
        drive(0, 15);
        drive(1, 2);
        drive(0, 8);
        expect_pulse(120, 30, 2, 4);
        drive(1, 120);
        drive(0, 10);
        check("glitch_one", glitch_count, 1);

        // overlong: one class-3 report, none until a fresh rise
        expect_pulse(1000, 130, 3, 5);
        drive(1, 1200);
        drive(0, 10);
        expect_pulse(5, 1210, 0, 6);
        drive(1, 5);
        drive(0, 10);
        expect_pulse(7, 15, 0, 7);
        drive(1, 7);
        drive(0, 3);

        // cnt_clr coincident with accept
        expect_pulse(4, 10, 0, 0);
        drive(1, 4);
        sigin = 1'b0;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        drive(0, 4);
        expect_pulse(12, 9, 1, 1);
        drive(1, 12);
        drive(0, 5);

        // width boundaries: MIN_WIDTH, TH1, TH2
        expect_pulse(3, 17, 0, 2);
        drive(1, 3);
        drive(0, 5);
        expect_pulse(10, 8, 1, 3);
        drive(1, 10);
        drive(0, 5);
        expect_pulse(100, 15, 2, 4);
        drive(1, 100);
        drive(0, 5);
        check("glitch_cleared", glitch_count, 0);
        check("count_before_rst", pulse_count, 4);

        // async reset mid-pulse
        drive(1, 40);
        rst_n = 1'b0;
        #1;
        check("arst_valid", pulse_valid, 0);
        check("arst_width", pulse_width, 0);
        check("arst_count", pulse_count, 0);
        check("arst_class", pulse_class, 0);
        drive(1, 2);
        rst_n = 1'b1;
        drive(1, 20);
        drive(0, 5);
        expect_pulse(6, 0, 0, 1);
        drive(1, 6);
        drive(0, 5);

        // enable low holds outputs and invalidates the period reference
        enable = 1'b0;
        drive(0, 3);
        check("hold_width", pulse_width, 6);
        check("hold_count", pulse_count, 1);
        enable = 1'b1;
        drive(0, 3);
        expect_pulse(8, 0, 0, 2);
        drive(1, 8);
        drive(0, 5);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
